// File: rtl/stream_mux_rr_pkg.sv
// Shared types and constants for the packet-aware stream multiplexer.
package stream_mux_rr_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Multi-channel input / single-channel output stream bundle with select controls.
interface stream_mux_rr_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SEL_W = $clog2(DEPTH)
);
  logic                              mode;
  logic [SEL_W-1:0]                  s;
  logic [DEPTH-1:0]                  in_valid;
  logic [DEPTH-1:0][WIDTH-1:0]       in_data;
  logic [DEPTH-1:0]                  in_last;
  logic [DEPTH-1:0]                  in_ready;
  logic                              out_valid;
  logic [WIDTH-1:0]                  out_data;
  logic                              out_last;
  logic [SEL_W-1:0]                  out_sel;
  logic                              out_ready;

  modport master (
    output mode, s, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  mode, s, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/stream_mux_rr_rr_pick.sv
// Combinational round-robin search: first requester strictly after ptr_i, wrapping.
module rr_pick #(
  parameter int DEPTH = 16,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [DEPTH-1:0] grant_o,
  output logic             found_o
);

  logic hit;

  always_comb begin
    grant_o = '0;
    hit     = 1'b0;
    // Upper half (above the pointer) has priority over the wrapped lower half.
    for (int k = 0; k < DEPTH; k++) begin
      if (!hit && (k > int'(ptr_i)) && req_i[k]) begin
        grant_o[k] = 1'b1;
        hit        = 1'b1;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (!hit && (k <= int'(ptr_i)) && req_i[k]) begin
        grant_o[k] = 1'b1;
        hit        = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Packet-aware N:1 stream multiplexer with explicit-select and round-robin modes
// and a single registered output stage.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  stream_mux_rr_if.slave    bus
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;

  logic [DEPTH-1:0]   rr_grant;
  logic               rr_found;
  logic [SEL_W-1:0]   rr_idx;
  logic               sel_ok;
  logic               cand_vld;
  logic [SEL_W-1:0]   cand_ch;
  logic               cand_in_valid;
  logic [WIDTH-1:0]   cand_data;
  logic               cand_last;
  logic               can_load;
  logic               grant_en;
  logic               accept;

  rr_pick #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_rr_pick (
    .req_i   (bus.in_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (rr_grant),
    .found_o (rr_found)
  );

  // Candidate selection; out-of-range select values never match a channel.
  always_comb begin
    sel_ok = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.s == SEL_W'(k)) sel_ok = bus.in_valid[k];
      if (rr_grant[k])        rr_idx = SEL_W'(k);
    end

    cand_vld = 1'b0;
    cand_ch  = '0;
    if (state_q == ST_LOCKED) begin
      cand_vld = 1'b1;
      cand_ch  = lock_ch_q;
    end else if (bus.mode == MODE_RR) begin
      cand_vld = rr_found;
      cand_ch  = rr_idx;
    end else begin
      cand_vld = sel_ok;
      cand_ch  = bus.s;
    end
  end

  always_comb begin
    can_load      = !out_valid_q || bus.out_ready;
    grant_en      = cand_vld && can_load && !rst;
    cand_in_valid = 1'b0;
    cand_data     = '0;
    cand_last     = 1'b0;
    bus.in_ready  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (cand_ch == SEL_W'(k)) begin
        cand_in_valid   = bus.in_valid[k];
        cand_data       = bus.in_data[k];
        cand_last       = bus.in_last[k];
        bus.in_ready[k] = grant_en;
      end
    end
    accept = grant_en && cand_in_valid;
  end

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = cand_data;
      out_last_d  = cand_last;
      out_sel_d   = cand_ch;
      if (cand_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = cand_ch;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = cand_ch;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= SEL_W'(DEPTH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 16-channel and a 12-channel instance.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(32), .DEPTH(16)) b0 ();
  stream_mux_rr_if #(.WIDTH(32), .DEPTH(12)) b1 ();

  stream_mux_rr #(.WIDTH(32), .DEPTH(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  stream_mux_rr #(.WIDTH(32), .DEPTH(12)) u1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_rr [6] = '{0, 4, 15, 0, 4, 15};

  initial begin
    // reset with every channel requesting
    b0.mode = 1'b1; b0.s = '0; b0.in_valid = 16'hFFFF; b0.in_last = 16'hFFFF; b0.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) b0.in_data[k] = 32'hA5A5_0000 | k;
    b1.mode = 1'b0; b1.s = '0; b1.in_valid = 12'hFFF; b1.in_last = 12'hFFF; b1.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) b1.in_data[k] = 32'hB0B0_0000 | k;
    rst = 1'b1;
    tick();
    chk("rst_in_ready_c1", b0.in_ready, 16'h0000);
    tick();
    chk("rst_in_ready_c2", b0.in_ready, 16'h0000);
    chk("rst_in_ready_d12", b1.in_ready, 12'h000);
    chk("rst_out_valid", b0.out_valid, 1'b0);
    chk("rst_out_data", b0.out_data, 32'h0);
    chk("rst_out_sel", b0.out_sel, 4'h0);

    // first RR grant after reset goes to channel 0
    rst = 1'b0;
    b1.in_valid = 12'h000;
    #1;
    chk("rr_first_ready", b0.in_ready, 16'h0001);
    tick();
    chk("rr_first_sel", b0.out_sel, 4'd0);
    chk("rr_first_data", b0.out_data, 32'hA5A5_0000);

    // explicit select of channel 5
    b0.mode = 1'b0; b0.s = 4'd5;
    #1;
    chk("sel5_ready", b0.in_ready, 16'h0020);
    tick();
    chk("sel5_data", b0.out_data, 32'hA5A5_0005);
    chk("sel5_sel", b0.out_sel, 4'd5);
    chk("sel5_last", b0.out_last, 1'b1);
    chk("sel5_valid", b0.out_valid, 1'b1);

    // top channel select boundary
    b0.s = 4'd15;
    #1;
    chk("sel15_ready", b0.in_ready, 16'h8000);
    tick();
    chk("sel15_sel", b0.out_sel, 4'd15);
    chk("sel15_data", b0.out_data, 32'hA5A5_000F);

    // round-robin fairness with wrap, single-word packets, one per cycle
    b0.mode = 1'b1; b0.in_valid = 16'h8011;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_ready_%0d", i), b0.in_ready, 16'h0001 << exp_rr[i]);
      tick();
      chk($sformatf("rr_sel_%0d", i), b0.out_sel, exp_rr[i]);
      chk($sformatf("rr_valid_%0d", i), b0.out_valid, 1'b1);
    end

    // 3-word packet on channel 2 with channel 3 contending and controls toggled
    b0.in_valid = 16'h000C; b0.in_last = 16'h0008;
    b0.in_data[2] = 32'h2222_0001; b0.in_data[3] = 32'h3333_0000;
    #1;
    chk("pkt_w1_ready", b0.in_ready, 16'h0004);
    tick();
    chk("pkt_w1_sel", b0.out_sel, 4'd2);
    chk("pkt_w1_data", b0.out_data, 32'h2222_0001);
    chk("pkt_w1_last", b0.out_last, 1'b0);
    b0.in_data[2] = 32'h2222_0002; b0.mode = 1'b0; b0.s = 4'd3;
    #1;
    chk("pkt_w2_ready", b0.in_ready, 16'h0004);
    tick();
    chk("pkt_w2_sel", b0.out_sel, 4'd2);
    chk("pkt_w2_data", b0.out_data, 32'h2222_0002);
    b0.in_data[2] = 32'h2222_0003; b0.in_last = 16'h000C; b0.mode = 1'b1; b0.s = 4'd7;
    #1;
    chk("pkt_w3_ready", b0.in_ready, 16'h0004);
    tick();
    chk("pkt_w3_sel", b0.out_sel, 4'd2);
    chk("pkt_w3_last", b0.out_last, 1'b1);
    #1;
    chk("pkt_next_ready", b0.in_ready, 16'h0008);
    tick();
    chk("pkt_next_sel", b0.out_sel, 4'd3);
    chk("pkt_next_data", b0.out_data, 32'h3333_0000);

    // backpressure: hold four cycles with a word registered
    b0.out_ready = 1'b0;
    b0.in_data[2] = 32'h2222_0004; b0.in_data[3] = 32'h3333_0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), b0.in_ready, 16'h0000);
      chk($sformatf("bp_data_%0d", i), b0.out_data, 32'h3333_0000);
      chk($sformatf("bp_valid_%0d", i), b0.out_valid, 1'b1);
      tick();
    end
    b0.out_ready = 1'b1;
    #1;
    chk("rel_ready_a", b0.in_ready, 16'h0004);
    tick();
    chk("rel_data_a", b0.out_data, 32'h2222_0004);
    chk("rel_sel_a", b0.out_sel, 4'd2);
    #1;
    chk("rel_ready_b", b0.in_ready, 16'h0008);
    tick();
    chk("rel_data_b", b0.out_data, 32'h3333_0001);
    chk("rel_sel_b", b0.out_sel, 4'd3);
    b0.in_valid = 16'h0000;
    #1;
    chk("drain_ready", b0.in_ready, 16'h0000);
    tick();
    chk("drain_valid", b0.out_valid, 1'b0);

    // 12-channel build: out-of-range select grants nothing, in-range top channel grants
    b1.mode = 1'b0; b1.s = 4'd13; b1.in_valid = 12'hFFF;
    #1;
    chk("d12_s13_ready", b1.in_ready, 12'h000);
    tick();
    chk("d12_s13_valid", b1.out_valid, 1'b0);
    b1.s = 4'd11;
    #1;
    chk("d12_s11_ready", b1.in_ready, 12'h800);
    tick();
    chk("d12_s11_sel", b1.out_sel, 4'd11);
    chk("d12_s11_data", b1.out_data, 32'hB0B0_000B);

    // reset in the middle of a packet on channel 2 (pointer currently 3)
    b0.mode = 1'b1; b0.in_valid = 16'h0004; b0.in_last = 16'h0000;
    #1;
    chk("mid_ready", b0.in_ready, 16'h0004);
    tick();
    chk("mid_sel", b0.out_sel, 4'd2);
    chk("mid_valid", b0.out_valid, 1'b1);
    rst = 1'b1; b0.in_valid = 16'h000C;
    #1;
    chk("mid_rst_ready", b0.in_ready, 16'h0000);
    tick();
    chk("mid_rst_valid", b0.out_valid, 1'b0);
    chk("mid_rst_data", b0.out_data, 32'h0);
    rst = 1'b0; b0.in_valid = 16'h0008;
    #1;
    chk("mid_idle_ready", b0.in_ready, 16'h0008);
    tick();
    chk("mid_idle_sel", b0.out_sel, 4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width per channel.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of input channels, legal range 2..64.
REQ-003 The block SHALL have parameter SEL_W, default $clog2(DEPTH): select and channel-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = explicit select, 1 = round-robin.
REQ-007 The block SHALL have port s, input, SEL_W bits: channel select used when mode=0.
REQ-008 The block SHALL have port in_valid, input, DEPTH bits: per-channel word valid.
REQ-009 The block SHALL have port in_data, input, DEPTH x WIDTH bits: per-channel data, packed array.
REQ-010 The block SHALL have port in_last, input, DEPTH bits: per-channel end-of-packet marker.
REQ-011 The block SHALL have port in_ready, output, DEPTH bits: per-channel accept.
REQ-012 The block SHALL have port out_valid, output, 1 bit: output register holds a word.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: registered data.
REQ-014 The block SHALL have port out_last, output, 1 bit: registered end-of-packet.
REQ-015 The block SHALL have port out_sel, output, SEL_W bits: source channel of the current output word.
REQ-016 The block SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-017 A transfer SHALL occur on channel k when in_valid[k] and in_ready[k] are both 1 at a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-018 The block SHALL contain a control FSM with two states: IDLE (no packet in flight) and LOCKED (packet in flight on channel lock_ch).
REQ-019 In IDLE with mode=0, the candidate SHALL be channel s, provided s<DEPTH and in_valid[s]=1; s>=DEPTH SHALL produce no grant.
REQ-020 In IDLE with mode=1, the candidate SHALL be the first channel with in_valid=1, searching upward from rr_ptr+1 modulo DEPTH.
REQ-021 In LOCKED, the candidate SHALL be lock_ch only; mode and s SHALL be ignored until the packet ends.
REQ-022 in_ready[k] SHALL be 1 only for the candidate channel, only when the output register can load (out_valid=0 or out_ready=1), and SHALL be combinational from the current state and inputs.
REQ-023 At most one in_ready bit SHALL be 1 in any cycle.
REQ-024 An accepted word SHALL appear on out_data, out_last and out_sel with out_valid=1 in the next cycle: 1-cycle latency, one word per cycle sustained throughput.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_last and out_sel SHALL hold stable.
REQ-026 An accepted word with in_last=0 SHALL move the FSM IDLE->LOCKED (or keep LOCKED) with lock_ch set to the granted channel.
REQ-027 An accepted word with in_last=1 SHALL move the FSM to IDLE; a single word with in_last=1 accepted in IDLE SHALL leave the FSM in IDLE.
REQ-028 rr_ptr SHALL update to the granted channel only when a word with in_last=1 is accepted, in either mode.
REQ-029 Round-robin wrap-around SHALL follow channel DEPTH-1 with channel 0.
REQ-030 Toggling mode or changing s while LOCKED SHALL have no effect until the next IDLE cycle.
REQ-031 When no candidate exists, all in_ready bits SHALL be 0 and the output register SHALL drain normally.

Reset
REQ-032 With rst=1 at a rising edge, state SHALL become IDLE, rr_ptr SHALL become DEPTH-1 (so channel 0 has first priority), and out_valid, out_data, out_last and out_sel SHALL all become 0.
REQ-033 While rst=1, in_ready SHALL be all 0.
REQ-034 Reset asserted mid-packet SHALL discard the output word and the lock; no partial-packet recovery SHALL be required.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (ST_IDLE, ST_LOCKED) and the mode constants (MODE_SEL=0, MODE_RR=1).
REQ-036 The round-robin search SHALL be a separate sub-module, rr_pick #(DEPTH), taking request vector and pointer and returning a one-hot grant and found flag; it SHALL be purely combinational.

Verification
REQ-037 Reset: assert rst for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0; the first post-reset grant in RR mode is channel 0.
REQ-038 Select mode: mode=0, s=5, in_valid=16'hFFFF, in_data[5]=32'hA5A5_0005, in_last=1, out_ready=1 -> in_ready=16'h0020; the next cycle out_data=32'hA5A5_0005, out_sel=5, out_last=1.
REQ-039 RR fairness: mode=1, in_valid=16'h8011, single-word packets, out_ready=1 -> grant order 0,4,15,0,4,... with one word per cycle.
REQ-040 Packet lock: mode=1, channel 2 sends a 3-word packet (last on the 3rd word) while channel 3 is valid throughout, and s/mode are toggled mid-packet -> out_sel=2,2,2 then 3; no interleave occurs.
REQ-041 Backpressure: hold out_ready=0 for 4 cycles with a word registered -> out_data stable and in_ready all 0; on release, one word per cycle with no loss or duplication.
REQ-042 Boundary: mode=0 with s=15 (DEPTH=16) -> channel 15 is granted; with a DEPTH=12 build and s=13 -> no grant; rst asserted mid-packet -> next cycle out_valid=0 and the FSM is in IDLE.
